// File: rtl/msrv32_pkg.sv
// ============================================================================
// Module   : msrv32_pkg
// Brief    : Shared encodings for the machine-mode trap/return controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package msrv32_pkg;

    typedef enum logic [1:0] {
        ST_RESET       = 2'b00,
        ST_OPERATING   = 2'b01,
        ST_TRAP_TAKEN  = 2'b10,
        ST_TRAP_RETURN = 2'b11
    } state_t;

    localparam logic [1:0] C_PC_BOOT = 2'b00;
    localparam logic [1:0] C_PC_EPC  = 2'b01;
    localparam logic [1:0] C_PC_TRAP = 2'b10;
    localparam logic [1:0] C_PC_NEXT = 2'b11;

    localparam logic [3:0] C_CAUSE_MISALIGNED_INSTR = 4'd0;
    localparam logic [3:0] C_CAUSE_ILLEGAL_INSTR    = 4'd2;
    localparam logic [3:0] C_CAUSE_BREAKPOINT       = 4'd3;
    localparam logic [3:0] C_CAUSE_MISALIGNED_LOAD  = 4'd4;
    localparam logic [3:0] C_CAUSE_MISALIGNED_STORE = 4'd6;
    localparam logic [3:0] C_CAUSE_ECALL_M          = 4'd11;
    localparam logic [3:0] C_CAUSE_M_SW_IRQ         = 4'd3;
    localparam logic [3:0] C_CAUSE_M_TIMER_IRQ      = 4'd7;
    localparam logic [3:0] C_CAUSE_M_EXT_IRQ        = 4'd11;

    localparam logic [4:0] C_OPCODE_SYSTEM = 5'b11100;
    localparam logic [2:0] C_FUNCT3_PRIV   = 3'b000;
    localparam logic [6:0] C_FUNCT7_ECALL  = 7'b0000000;
    localparam logic [4:0] C_RS2_ECALL     = 5'b00000;
    localparam logic [4:0] C_RS2_EBREAK    = 5'b00001;
    localparam logic [6:0] C_FUNCT7_MRET   = 7'b0011000;
    localparam logic [4:0] C_RS2_MRET      = 5'b00010;
    localparam logic [6:0] C_FUNCT7_WFI    = 7'b0001000;
    localparam logic [4:0] C_RS2_WFI       = 5'b00101;

endpackage

`default_nettype wire

// File: rtl/msrv32_trap_cause_enc.sv
// ============================================================================
// Module   : msrv32_trap_cause_enc
// Brief    : Combinational priority encoder from trap flags to mcause fields.
// Revision : 1.0
// ============================================================================
`default_nettype none

module msrv32_trap_cause_enc
    import msrv32_pkg::*;
(
    input  logic       i_misaligned_instr,
    input  logic       i_illegal_instr,
    input  logic       i_ebreak,
    input  logic       i_ecall,
    input  logic       i_misaligned_load,
    input  logic       i_misaligned_store,
    input  logic       i_mie,
    input  logic       i_meie,
    input  logic       i_mtie,
    input  logic       i_msie,
    input  logic       i_e_irq,
    input  logic       i_t_irq,
    input  logic       i_s_irq,
    output logic       o_exc,
    output logic       o_irq,
    output logic [3:0] o_cause,
    output logic       o_i_or_e,
    output logic       o_misaligned
);

    logic w_ext;
    logic w_sw;
    logic w_tmr;

    assign w_ext = i_meie & i_e_irq;
    assign w_sw  = i_msie & i_s_irq;
    assign w_tmr = i_mtie & i_t_irq;

    assign o_exc = i_misaligned_instr | i_illegal_instr | i_ebreak | i_ecall |
                   i_misaligned_load | i_misaligned_store;
    assign o_irq = i_mie & (w_ext | w_sw | w_tmr);

    // Exceptions outrank interrupts; within each class the chain order is priority.
    always_comb begin
        o_cause      = 4'd0;
        o_i_or_e     = 1'b0;
        o_misaligned = 1'b0;
        if (o_exc) begin
            if (i_misaligned_instr) begin
                o_cause      = C_CAUSE_MISALIGNED_INSTR;
                o_misaligned = 1'b1;
            end else if (i_illegal_instr) begin
                o_cause = C_CAUSE_ILLEGAL_INSTR;
            end else if (i_ebreak) begin
                o_cause = C_CAUSE_BREAKPOINT;
            end else if (i_ecall) begin
                o_cause = C_CAUSE_ECALL_M;
            end else if (i_misaligned_load) begin
                o_cause      = C_CAUSE_MISALIGNED_LOAD;
                o_misaligned = 1'b1;
            end else begin
                o_cause      = C_CAUSE_MISALIGNED_STORE;
                o_misaligned = 1'b1;
            end
        end else if (o_irq) begin
            o_i_or_e = 1'b1;
            if (w_ext) begin
                o_cause = C_CAUSE_M_EXT_IRQ;
            end else if (w_sw) begin
                o_cause = C_CAUSE_M_SW_IRQ;
            end else begin
                o_cause = C_CAUSE_M_TIMER_IRQ;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/msrv32_trap_ctrl.sv
// ============================================================================
// Module   : msrv32_trap_ctrl
// Brief    : Machine-mode trap entry / MRET sequencer with PC, flush and CSR strobes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module msrv32_trap_ctrl
    import msrv32_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       misaligned_instr_in,
    input  logic [4:0] opcode_6_to_2_in,
    input  logic [2:0] funct3_in,
    input  logic [6:0] funct7_in,
    input  logic [4:0] rs1_addr_in,
    input  logic [4:0] rs2_addr_in,
    input  logic [4:0] rd_addr_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       e_irq_in,
    input  logic       t_irq_in,
    input  logic       s_irq_in,
    output logic       trap_taken_out,
    output logic [1:0] pc_src_out,
    output logic       flush_out,
    output logic       set_epc_out,
    output logic       set_cause_out,
    output logic [3:0] cause_out,
    output logic       i_or_e_out,
    output logic       misaligned_exception_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic       instret_inc_out
);

    state_t     r_state;
    state_t     w_next_state;
    logic       w_system;
    logic       w_ecall;
    logic       w_ebreak;
    logic       w_mret;
    logic       w_exc;
    logic       w_irq;
    logic [3:0] w_cause;
    logic       w_i_or_e;
    logic       w_misaligned;
    logic       w_take;
    logic [3:0] r_cause;
    logic       r_i_or_e;
    logic       r_misaligned;

    // WFI is not decoded: it retires as an ordinary instruction.
    assign w_system = (opcode_6_to_2_in == C_OPCODE_SYSTEM) && (funct3_in == C_FUNCT3_PRIV) &&
                      (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
    assign w_ecall  = w_system && (funct7_in == C_FUNCT7_ECALL) && (rs2_addr_in == C_RS2_ECALL);
    assign w_ebreak = w_system && (funct7_in == C_FUNCT7_ECALL) && (rs2_addr_in == C_RS2_EBREAK);
    assign w_mret   = w_system && (funct7_in == C_FUNCT7_MRET) && (rs2_addr_in == C_RS2_MRET);

    msrv32_trap_cause_enc u_cause_enc (
        .i_misaligned_instr (misaligned_instr_in),
        .i_illegal_instr    (illegal_instr_in),
        .i_ebreak           (w_ebreak),
        .i_ecall            (w_ecall),
        .i_misaligned_load  (misaligned_load_in),
        .i_misaligned_store (misaligned_store_in),
        .i_mie              (mie_in),
        .i_meie             (meie_in),
        .i_mtie             (mtie_in),
        .i_msie             (msie_in),
        .i_e_irq            (e_irq_in),
        .i_t_irq            (t_irq_in),
        .i_s_irq            (s_irq_in),
        .o_exc              (w_exc),
        .o_irq              (w_irq),
        .o_cause            (w_cause),
        .o_i_or_e           (w_i_or_e),
        .o_misaligned       (w_misaligned)
    );

    assign w_take = (r_state == ST_OPERATING) && (w_exc || w_irq);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Cause fields are captured only on trap entry and held until the next trap.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cause      <= 4'd0;
            r_i_or_e     <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (w_take) begin
            r_cause      <= w_cause;
            r_i_or_e     <= w_i_or_e;
            r_misaligned <= w_misaligned;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        trap_taken_out  = 1'b0;
        pc_src_out      = C_PC_BOOT;
        flush_out       = 1'b0;
        set_epc_out     = 1'b0;
        set_cause_out   = 1'b0;
        mie_clear_out   = 1'b0;
        mie_set_out     = 1'b0;
        instret_inc_out = 1'b0;
        case (r_state)
            ST_RESET: begin
                flush_out    = 1'b1;
                w_next_state = ST_OPERATING;
            end
            ST_OPERATING: begin
                pc_src_out      = C_PC_NEXT;
                trap_taken_out  = w_take;
                instret_inc_out = ~(w_exc | w_irq);
                if (w_exc || w_irq) begin
                    w_next_state = ST_TRAP_TAKEN;
                end else if (w_mret) begin
                    w_next_state = ST_TRAP_RETURN;
                end
            end
            ST_TRAP_TAKEN: begin
                pc_src_out    = C_PC_TRAP;
                flush_out     = 1'b1;
                set_epc_out   = 1'b1;
                set_cause_out = 1'b1;
                mie_clear_out = 1'b1;
                w_next_state  = ST_OPERATING;
            end
            default: begin
                pc_src_out   = C_PC_EPC;
                flush_out    = 1'b1;
                mie_set_out  = 1'b1;
                w_next_state = ST_OPERATING;
            end
        endcase
    end

    assign cause_out                = r_cause;
    assign i_or_e_out               = r_i_or_e;
    assign misaligned_exception_out = r_misaligned;

endmodule

`default_nettype wire
